wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  MEM->WB pipeline stage; the sole driver of the register file write port (we/waddr/wdata).
//  Retires ALU results one cycle after capture; blocks the pipeline on loads until the data memory responds.
//  Aligns and sign- or zero-extends load data before writeback.
//  Sits between the MEM stage / dmem response and regfile; raises stallreq_o to the pipeline controller.
// PARAMETERS
//  DATA_W   32  register/data width (`RegBus)
//  ADDR_W    5  register address width (`RegAddrBus)
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous reset, active-low (0 = reset)
//  stall_i          in   1       1: MEM stage holds; no capture this edge
//  flush_i          in   1       1: kill captured/pending instruction (sync)
//  mem_we_i         in   1       MEM instruction writes a register
//  mem_waddr_i      in   ADDR_W  destination register
//  mem_wdata_i      in   DATA_W  ALU result (ignored for loads)
//  mem_is_load_i    in   1       instruction is a load
//  mem_ld_size_i    in   2       00 byte, 01 half, 10 word, 11 reserved
//  mem_ld_sign_i    in   1       1: sign-extend, 0: zero-extend
//  mem_ld_off_i     in   2       byte offset within the word (addr[1:0])
//  dmem_rvalid_i    in   1       read data valid (single-cycle pulse)
//  dmem_rdata_i     in   DATA_W  read word, big-endian (offset 0 = bits 31:24)
//  wb_we_o          out  1       regfile write enable (1-cycle pulse)
//  wb_waddr_o       out  ADDR_W  regfile write address
//  wb_wdata_o       out  DATA_W  regfile write data
//  stallreq_o       out  1       request whole-pipeline stall
//  ld_misalign_o    out  1       1-cycle pulse: misaligned load dropped
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; captured fields 0.
//  States: IDLE, WAIT_LD, DISCARD.
//  Capture: at a rising edge with state=IDLE, stall_i=0, flush_i=0 and mem_we_i=1.
//  - Capture with mem_waddr_i=0: treated as a no-op; no write is ever issued.
//  - Non-load capture: wb_we_o=1 with the captured addr/data in the next cycle only (exactly one pulse).
//  - Load capture: latch waddr/size/sign/off; next state WAIT_LD.
//  - Misaligned load (half & off[0]=1, word & off!=0, size=11): no WAIT_LD entered.
//    ld_misalign_o pulses the next cycle; no write.
//  WAIT_LD: stallreq_o=1 combinationally while dmem_rvalid_i=0.
//  - rvalid=1: extract the lane, extend to DATA_W, register it.
//    wb_we_o pulses next cycle; return to IDLE.
//  - Load return latency: 1 cycle after rvalid.
//  - flush_i=1 with rvalid=0: go to DISCARD. flush_i=1 with rvalid=1: drop data, go to IDLE.
//  DISCARD: stallreq_o=1 until rvalid; the response is dropped; return to IDLE.
//  - No write is issued. No capture occurs in WAIT_LD or DISCARD.
//  - rvalid in IDLE is ignored.
//  Lane select (big-endian): byte off k -> bits[31-8k -: 8]; half off 0 -> [31:16], off 2 -> [15:0].
//  flush_i=1 in the same cycle as a pending non-load write pulse: the pulse still occurs.
//  - The instruction was already retired.
//  stall_i=1: no capture; the outstanding pulse still completes; wb_we_o never repeats.
// STRUCTURE
//  Shared package/defines: `RegBus, `RegAddrBus, LD_BYTE/LD_HALF/LD_WORD encodings,
//  WB_IDLE/WB_WAIT_LD/WB_DISCARD state encodings.
//  Sub-module: load_align (combinational: rdata, size, sign, off -> extended word, misalign flag).
//  It is reused by the MEM stage.
// TESTING
//  1. ALU write: we=1, waddr=5, wdata=32'h1234_5678, stall=0 -> next cycle we_o=1, waddr_o=5, wdata_o=32'h1234_5678.
//     we_o=0 the cycle after.
//  2. Signed byte load off=1, rvalid 3 cycles later, rdata=32'h11_F0_22_33 -> stallreq_o=1 for 3 cycles.
//     The cycle after rvalid: wdata_o=32'hFFFF_FFF0.
//  3. Zero-extend half off=2, rdata=32'hAAAA_8001 -> wdata_o=32'h0000_8001.
//     Word off=0, rdata=32'hDEAD_BEEF -> wdata_o=32'hDEAD_BEEF.
//  4. Flush in WAIT_LD, rvalid 2 cycles later -> no we_o; stallreq_o stays 1 until rvalid.
//     A new capture succeeds the cycle after.
//  5. Misaligned word load off=2 -> ld_misalign_o pulse, no we_o, no stallreq_o.
//     A load with waddr=0 completes its stall but issues no write.
//  6. rst driven 0 mid-WAIT_LD (asynchronous, between edges) -> outputs 0 immediately.
//     The later rvalid is ignored; the stage resumes from IDLE.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage and the load alignment helper.
// Register widths, load size encodings and writeback state encodings.
package wb_stage_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WAIT_LD = 2'd1,
    WB_DISCARD = 2'd2
  } wb_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic w_bad;
    w_bad = 1'b0;
    case (size)
      LD_HALF: w_bad = off[0];
      LD_WORD: w_bad = (off != 2'b00);
      LD_RSVD: w_bad = 1'b1;
      default: w_bad = 1'b0;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian lane extraction and sign/zero extension of a data memory read word.
// Purely combinational; also flags size/offset combinations that cannot be served.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  input  logic [1:0]        i_off,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [DATA_W-1:0] w_shifted;

  // Shifting left by the byte offset moves the addressed lane to the top of the word.
  always_comb begin
    w_shifted = i_rdata << {i_off, 3'b000};
    o_data    = i_rdata;
    case (i_size)
      LD_BYTE: o_data = {{(DATA_W-8){i_sign & w_shifted[DATA_W-1]}}, w_shifted[DATA_W-1 -: 8]};
      LD_HALF: o_data = {{(DATA_W-16){i_sign & w_shifted[DATA_W-1]}}, w_shifted[DATA_W-1 -: 16]};
      default: o_data = i_rdata;
    endcase
  end

  assign o_misalign = is_misaligned(i_size, i_off);

endmodule

// File: rtl/wb_stage.sv
// MEM->WB stage: sole driver of the regfile write port; ALU results retire one cycle after capture,
// loads hold the pipeline via stallreq_o until the data memory responds, then write one cycle later.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_is_load_i,
  input  logic [1:0]        mem_ld_size_i,
  input  logic              mem_ld_sign_i,
  input  logic [1:0]        mem_ld_off_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              stallreq_o,
  output logic              ld_misalign_o
);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic              w_idle;
  logic              w_capture;
  logic              w_stallreq;
  logic [1:0]        w_al_size;
  logic [1:0]        w_al_off;
  logic              w_al_sign;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_misalign;

  logic [ADDR_W-1:0] r_ld_waddr;
  logic [1:0]        r_ld_size;
  logic              r_ld_sign;
  logic [1:0]        r_ld_off;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_misalign;

  assign w_idle    = (r_state == WB_IDLE);
  assign w_capture = w_idle & ~stall_i & ~flush_i & mem_we_i;

  // One aligner serves both jobs: misalign check on the incoming load while idle,
  // lane extraction with the latched attributes while waiting.
  assign w_al_size = w_idle ? mem_ld_size_i : r_ld_size;
  assign w_al_off  = w_idle ? mem_ld_off_i  : r_ld_off;
  assign w_al_sign = w_idle ? mem_ld_sign_i : r_ld_sign;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .i_rdata    (dmem_rdata_i),
    .i_size     (w_al_size),
    .i_sign     (w_al_sign),
    .i_off      (w_al_off),
    .o_data     (w_ld_data),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stallreq  = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (w_capture && mem_is_load_i && !w_misalign) w_state_nxt = WB_WAIT_LD;
      end
      WB_WAIT_LD: begin
        w_stallreq = ~dmem_rvalid_i;
        if (dmem_rvalid_i)  w_state_nxt = WB_IDLE;
        else if (flush_i)   w_state_nxt = WB_DISCARD;
      end
      WB_DISCARD: begin
        w_stallreq = ~dmem_rvalid_i;
        if (dmem_rvalid_i) w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  // Writes to r0 are swallowed here so the regfile never sees them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_waddr <= '0;
      r_ld_size  <= '0;
      r_ld_sign  <= 1'b0;
      r_ld_off   <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_misalign <= 1'b0;
      if (w_capture) begin
        if (!mem_is_load_i) begin
          if (mem_waddr_i != '0) begin
            r_we    <= 1'b1;
            r_waddr <= mem_waddr_i;
            r_wdata <= mem_wdata_i;
          end
        end else if (w_misalign) begin
          r_misalign <= 1'b1;
        end else begin
          r_ld_waddr <= mem_waddr_i;
          r_ld_size  <= mem_ld_size_i;
          r_ld_sign  <= mem_ld_sign_i;
          r_ld_off   <= mem_ld_off_i;
        end
      end
      if ((r_state == WB_WAIT_LD) && dmem_rvalid_i && !flush_i && (r_ld_waddr != '0)) begin
        r_we    <= 1'b1;
        r_waddr <= r_ld_waddr;
        r_wdata <= w_ld_data;
      end
    end
  end

  assign wb_we_o       = r_we;
  assign wb_waddr_o    = r_waddr;
  assign wb_wdata_o    = r_wdata;
  assign stallreq_o    = w_stallreq;
  assign ld_misalign_o = r_misalign;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a cycle-level behavioural model and literal spot checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, mem_we_i, mem_is_load_i, mem_ld_sign_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [1:0]  mem_ld_size_i, mem_ld_off_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_we_o, stallreq_o, ld_misalign_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_is_load_i(mem_is_load_i), .mem_ld_size_i(mem_ld_size_i),
    .mem_ld_sign_i(mem_ld_sign_i), .mem_ld_off_i(mem_ld_off_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .stallreq_o(stallreq_o), .ld_misalign_o(ld_misalign_o)
  );

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] extract(input logic [1:0] size, input logic sign,
                                          input logic [1:0] off, input logic [31:0] w);
    logic [31:0] v;
    int unsigned sh;
    v = w;
    if (size == 2'd0) begin
      sh = 8 * (3 - int'(off));
      v  = (w >> sh) & 32'h0000_00FF;
      if (sign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      sh = 8 * (2 - int'(off));
      v  = (w >> sh) & 32'h0000_FFFF;
      if (sign && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) || (size == 2'd2 && off != 2'd0) || (size == 2'd1 && off[0]);
  endfunction

  logic        m_pending, m_killed;
  logic [4:0]  m_addr;
  logic [1:0]  m_size, m_off;
  logic        m_sign;
  logic        exp_we, exp_mis;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending <= 1'b0; m_killed <= 1'b0;
      m_addr <= '0; m_size <= '0; m_off <= '0; m_sign <= 1'b0;
      exp_we <= 1'b0; exp_mis <= 1'b0; exp_addr <= '0; exp_data <= '0;
    end else begin
      exp_we  <= 1'b0;
      exp_mis <= 1'b0;
      if (m_pending) begin
        if (dmem_rvalid_i) begin
          m_pending <= 1'b0;
          m_killed  <= 1'b0;
          if (!m_killed && !flush_i && m_addr != 5'd0) begin
            exp_we   <= 1'b1;
            exp_addr <= m_addr;
            exp_data <= extract(m_size, m_sign, m_off, dmem_rdata_i);
          end
        end else if (flush_i) begin
          m_killed <= 1'b1;
        end
      end else if (mem_we_i && !stall_i && !flush_i) begin
        if (!mem_is_load_i) begin
          if (mem_waddr_i != 5'd0) begin
            exp_we   <= 1'b1;
            exp_addr <= mem_waddr_i;
            exp_data <= mem_wdata_i;
          end
        end else if (bad_align(mem_ld_size_i, mem_ld_off_i)) begin
          exp_mis <= 1'b1;
        end else begin
          m_pending <= 1'b1;
          m_addr <= mem_waddr_i; m_size <= mem_ld_size_i;
          m_off  <= mem_ld_off_i; m_sign <= mem_ld_sign_i;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (wb_we_o !== exp_we) begin
        n_fail++; $display("FAIL cyc_we t=%0t: got %b expected %b", $time, wb_we_o, exp_we);
      end
      n_checks++;
      if (ld_misalign_o !== exp_mis) begin
        n_fail++; $display("FAIL cyc_misalign t=%0t: got %b expected %b", $time, ld_misalign_o, exp_mis);
      end
      n_checks++;
      if (stallreq_o !== (m_pending && !dmem_rvalid_i)) begin
        n_fail++; $display("FAIL cyc_stallreq t=%0t: got %b expected %b", $time, stallreq_o,
                           m_pending && !dmem_rvalid_i);
      end
      if (exp_we) begin
        n_checks++;
        if (wb_waddr_o !== exp_addr || wb_wdata_o !== exp_data) begin
          n_fail++; $display("FAIL cyc_wdat t=%0t: got %0d/%h expected %0d/%h", $time,
                             wb_waddr_o, wb_wdata_o, exp_addr, exp_data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall_i = 1'b0; flush_i = 1'b0; mem_we_i = 1'b0; mem_is_load_i = 1'b0;
    mem_waddr_i = '0; mem_wdata_i = '0; mem_ld_size_i = '0; mem_ld_sign_i = 1'b0;
    mem_ld_off_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic set_alu(input logic [4:0] a, input logic [31:0] d);
    mem_we_i = 1'b1; mem_is_load_i = 1'b0; mem_waddr_i = a; mem_wdata_i = d;
  endtask

  task automatic set_load(input logic [4:0] a, input logic [1:0] size, input logic sign,
                          input logic [1:0] off);
    mem_we_i = 1'b1; mem_is_load_i = 1'b1; mem_waddr_i = a;
    mem_ld_size_i = size; mem_ld_sign_i = sign; mem_ld_off_i = off;
    mem_wdata_i = 32'hBAD0_BAD0;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] expv;
  } ld_vec_t;

  ld_vec_t vecs[6];

  initial begin
    vecs[0] = '{2'd1, 1'b0, 2'd2, 32'hAAAA_8001, 32'h0000_8001};
    vecs[1] = '{2'd2, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{2'd1, 1'b1, 2'd2, 32'hAAAA_8001, 32'hFFFF_8001};
    vecs[3] = '{2'd0, 1'b0, 2'd3, 32'h11F0_2233, 32'h0000_0033};
    vecs[4] = '{2'd0, 1'b1, 2'd0, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[5] = '{2'd1, 1'b1, 2'd0, 32'h7FFF_8000, 32'h0000_7FFF};

    rst = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    lit("rst_we", {31'b0, wb_we_o}, 32'd0);
    lit("rst_stallreq", {31'b0, stallreq_o}, 32'd0);
    lit("rst_wdata", wb_wdata_o, 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    tick();

    // ALU write
    set_alu(5'd5, 32'h1234_5678);
    tick(); clr();
    lit("alu_we", {31'b0, wb_we_o}, 32'd1);
    lit("alu_waddr", {27'b0, wb_waddr_o}, 32'd5);
    lit("alu_wdata", wb_wdata_o, 32'h1234_5678);
    tick();
    lit("alu_we_after", {31'b0, wb_we_o}, 32'd0);

    // Signed byte load, three stall cycles before the response
    set_load(5'd7, 2'd0, 1'b1, 2'd1);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      lit("sb_stallreq", {31'b0, stallreq_o}, 32'd1);
      tick();
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11F0_2233;
    #1;
    lit("sb_stall_drop", {31'b0, stallreq_o}, 32'd0);
    tick(); clr();
    lit("sb_we", {31'b0, wb_we_o}, 32'd1);
    lit("sb_wdata", wb_wdata_o, 32'hFFFF_FFF0);
    tick();

    // Lane/extension table
    for (int i = 0; i < 6; i++) begin
      set_load(5'(20 + i), vecs[i].size, vecs[i].sign, vecs[i].off);
      tick(); clr();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = vecs[i].rdata;
      tick(); clr();
      lit("ld_tab_we", {31'b0, wb_we_o}, 32'd1);
      lit("ld_tab_wdata", wb_wdata_o, vecs[i].expv);
    end
    tick();

    // Flush while waiting, response two cycles later is dropped
    set_load(5'd11, 2'd2, 1'b0, 2'd0);
    tick(); clr();
    flush_i = 1'b1;
    #1;
    lit("fl_stallreq0", {31'b0, stallreq_o}, 32'd1);
    tick(); clr();
    lit("fl_stallreq1", {31'b0, stallreq_o}, 32'd1);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    tick(); clr();
    lit("fl_no_we", {31'b0, wb_we_o}, 32'd0);
    set_alu(5'd3, 32'h0000_CAFE);
    tick(); clr();
    lit("fl_recap_we", {31'b0, wb_we_o}, 32'd1);
    lit("fl_recap_wdata", wb_wdata_o, 32'h0000_CAFE);

    // Flush with response in the same cycle drops the data
    set_load(5'd12, 2'd2, 1'b0, 2'd0);
    tick(); clr();
    flush_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    tick(); clr();
    lit("flrv_no_we", {31'b0, wb_we_o}, 32'd0);

    // Misaligned word load
    set_load(5'd13, 2'd2, 1'b0, 2'd2);
    tick(); clr();
    lit("mis_pulse", {31'b0, ld_misalign_o}, 32'd1);
    lit("mis_no_stall", {31'b0, stallreq_o}, 32'd0);
    tick();
    lit("mis_pulse_end", {31'b0, ld_misalign_o}, 32'd0);

    // Load to r0 stalls but never writes
    set_load(5'd0, 2'd0, 1'b0, 2'd0);
    tick(); clr();
    lit("r0_stallreq", {31'b0, stallreq_o}, 32'd1);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFF00_0000;
    tick(); clr();
    lit("r0_no_we", {31'b0, wb_we_o}, 32'd0);

    // Flush alongside a pending ALU pulse, stall blocks capture, rvalid in idle ignored
    set_alu(5'd4, 32'hA5A5_5A5A);
    tick(); clr();
    flush_i = 1'b1;
    lit("flpulse_we", {31'b0, wb_we_o}, 32'd1);
    tick(); clr();
    stall_i = 1'b1; set_alu(5'd8, 32'h0000_0008);
    tick(); clr();
    lit("stall_no_we", {31'b0, wb_we_o}, 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_0000;
    tick(); clr();
    lit("idle_rvalid_no_we", {31'b0, wb_we_o}, 32'd0);

    // Async reset in the middle of a load wait
    set_load(5'd14, 2'd2, 1'b0, 2'd0);
    tick(); clr();
    tick();
    #2 rst = 1'b0;
    #1;
    lit("arst_stallreq", {31'b0, stallreq_o}, 32'd0);
    lit("arst_we", {31'b0, wb_we_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    tick(); clr();
    lit("arst_rvalid_ignored", {31'b0, wb_we_o}, 32'd0);
    set_alu(5'd6, 32'h0000_0055);
    tick(); clr();
    lit("arst_resume_we", {31'b0, wb_we_o}, 32'd1);
    lit("arst_resume_waddr", {27'b0, wb_waddr_o}, 32'd6);
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
